// File: rtl/srambus2axi_burst_if.sv
// AXI3 master-side bus bundle for srambus2axi_burst.
// The master modport drives the address channels, the write data and the B/R ready signals.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 7
`endif

interface srambus2axi_burst_if #(
  parameter int unsigned DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH   = `AXI_ID_WIDTH
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/srambus2axi_burst.sv
// SRAM-bus to AXI3 burst bridge: one INCR read and one INCR write in flight, region-decoded IDs.
// Optional SRAMBUS2AXI_RAW_CHECK_EN holds off reads to the address of the outstanding write.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 7
`endif

module srambus2axi_burst #(
  parameter int unsigned DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int unsigned ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int unsigned MID_WIDTH  = 3,
  parameter int unsigned SLV_NUM    = 4,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  srambus2axi_burst_if.master     axi,
  input  logic                    mem_req,
  input  logic                    mem_wen,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [2:0]              mem_size,
  input  logic [3:0]              mem_len,
  input  logic [MID_WIDTH-1:0]    mem_match_id,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic                    mem_addr_ok,
  output logic                    mem_wbeat_ok,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_data_ok,
  output logic                    mem_rlast,
  output logic                    mem_err,
  input  logic                    mem_data_resp,
  output logic                    writing,
  output logic [ADDR_WIDTH-1:0]   last_write_address
);
  localparam int unsigned CntW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d, arid_q, arid_d;
  logic [3:0]            awlen_q, awlen_d, arlen_q, arlen_d;
  logic [2:0]            awsize_q, awsize_d, arsize_q, arsize_d;
  logic [CntW-1:0]       w_cnt_q, w_cnt_d;
  logic [ADDR_WIDTH-1:0] last_write_address_q, last_write_address_d;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ID_WIDTH-1:0]   req_id;
  logic                  raw_block, wr_accept, rd_accept;
  logic                  w_last, r_beat, b_hs;

  // Thermometer slave code: mem=0001, timer=0011, uart=0111, gpio=1111, unmapped -> mem.
  function automatic logic [SLV_NUM-1:0] slv_code(input logic [3:0] region);
    int unsigned sel;
    logic [SLV_NUM-1:0] code;
    case (region)
      4'd2:    sel = 1;
      4'd3:    sel = 2;
      4'd4:    sel = 3;
      default: sel = 0;
    endcase
    for (int unsigned i = 0; i < SLV_NUM; i++) code[i] = (i <= sel);
    return code;
  endfunction

  always_comb begin
    req_addr = mem_address;
    req_addr[ADDR_WIDTH-1 -: 4] = 4'b0;
  end
  assign req_id = {mem_match_id, slv_code(mem_address[ADDR_WIDTH-1 -: 4])};

  assign writing            = (w_state_q != WIdle);
  assign last_write_address = last_write_address_q;

`ifdef SRAMBUS2AXI_RAW_CHECK_EN
  assign raw_block = writing && (mem_address == last_write_address_q);
`else
  assign raw_block = 1'b0;
`endif

  assign wr_accept   = mem_req && mem_wen && (w_state_q == WIdle);
  assign rd_accept   = mem_req && !mem_wen && (r_state_q == RIdle) && !raw_block;
  assign mem_addr_ok = wr_accept || rd_accept;

  assign w_last = (w_cnt_q == awlen_q[CntW-1:0]);
  assign r_beat = (r_state_q == RData) && axi.rvalid && mem_data_resp;
  // A read beat owns the completion port this cycle; the B response waits one cycle.
  assign b_hs   = (w_state_q == WResp) && axi.bvalid && !r_beat;

  always_comb begin
    w_state_d            = w_state_q;
    awaddr_d             = awaddr_q;
    awid_d               = awid_q;
    awlen_d              = awlen_q;
    awsize_d             = awsize_q;
    w_cnt_d              = w_cnt_q;
    last_write_address_d = last_write_address_q;
    unique case (w_state_q)
      WIdle: begin
        if (wr_accept) begin
          w_state_d            = WAddr;
          awaddr_d             = req_addr;
          awid_d               = req_id;
          awlen_d              = mem_len;
          awsize_d             = mem_size;
          w_cnt_d              = '0;
          last_write_address_d = mem_address;
        end
      end
      WAddr: if (axi.awready) w_state_d = WData;
      WData: begin
        if (axi.wready) begin
          if (w_last) w_state_d = WResp;
          else        w_cnt_d   = w_cnt_q + CntW'(1);
        end
      end
      WResp: if (b_hs) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    unique case (r_state_q)
      RIdle: begin
        if (rd_accept) begin
          r_state_d = RAddr;
          araddr_d  = req_addr;
          arid_d    = req_id;
          arlen_d   = mem_len;
          arsize_d  = mem_size;
        end
      end
      RAddr: if (axi.arready) r_state_d = RData;
      RData: if (r_beat && axi.rlast) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q            <= WIdle;
      r_state_q            <= RIdle;
      awaddr_q             <= '0;
      awid_q               <= '0;
      awlen_q              <= '0;
      awsize_q             <= '0;
      araddr_q             <= '0;
      arid_q               <= '0;
      arlen_q              <= '0;
      arsize_q             <= '0;
      w_cnt_q              <= '0;
      last_write_address_q <= '0;
    end else begin
      w_state_q            <= w_state_d;
      r_state_q            <= r_state_d;
      awaddr_q             <= awaddr_d;
      awid_q               <= awid_d;
      awlen_q              <= awlen_d;
      awsize_q             <= awsize_d;
      araddr_q             <= araddr_d;
      arid_q               <= arid_d;
      arlen_q              <= arlen_d;
      arsize_q             <= arsize_d;
      w_cnt_q              <= w_cnt_d;
      last_write_address_q <= last_write_address_d;
    end
  end

  assign axi.awid    = awid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (w_state_q == WAddr);
  assign axi.wid     = awid_q;
  assign axi.wdata   = mem_wdata;
  assign axi.wstrb   = mem_wmask;
  assign axi.wvalid  = (w_state_q == WData);
  assign axi.wlast   = (w_state_q == WData) && w_last;
  assign axi.bready  = (w_state_q == WResp) && !r_beat;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (r_state_q == RAddr);
  assign axi.rready  = (r_state_q == RData) && mem_data_resp;

  assign mem_wbeat_ok = (w_state_q == WData) && axi.wready;
  assign mem_data_ok  = r_beat || b_hs;
  assign mem_rdata    = r_beat ? axi.rdata : '0;
  assign mem_rlast    = r_beat && axi.rlast;
  assign mem_err      = r_beat ? (axi.rresp != 2'b00) : (b_hs && (axi.bresp != 2'b00));
endmodule

// File: tb/tb_srambus2axi_burst.sv
// Self-checking bench for srambus2axi_burst: vector table of bursts, scoreboard on mem_data_ok,
// plus hand sequences for B/R collision, read-after-write hazard and mid-burst reset.
module tb_srambus2axi_burst;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_wen, mem_data_resp;
  logic [31:0] mem_address, mem_wdata;
  logic [2:0]  mem_size, mem_match_id;
  logic [3:0]  mem_len, mem_wmask;
  logic        mem_addr_ok, mem_wbeat_ok, mem_data_ok, mem_rlast, mem_err, writing;
  logic [31:0] mem_rdata, last_write_address;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [31:0] data; logic last; logic err;} exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [2:0]  mid;
    int          len;
    logic [1:0]  resp;
    int          stall;
    logic [31:0] exp_addr;
    logic [6:0]  exp_id;
  } vec_t;
  vec_t vecs[7];

  srambus2axi_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(7)) axi ();

  srambus2axi_burst #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(7), .MID_WIDTH(3), .SLV_NUM(4), .MAX_LEN(16)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n), .axi(axi),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_address(mem_address), .mem_size(mem_size),
    .mem_len(mem_len), .mem_match_id(mem_match_id), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_addr_ok(mem_addr_ok), .mem_wbeat_ok(mem_wbeat_ok),
    .mem_rdata(mem_rdata), .mem_data_ok(mem_data_ok), .mem_rlast(mem_rlast), .mem_err(mem_err),
    .mem_data_resp(mem_data_resp), .writing(writing), .last_write_address(last_write_address)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Completion monitor: every mem_data_ok must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mem_data_ok === 1'b1) begin
      if (sb.size() == 0) chk("unexpected data_ok", mem_data_ok, 1'b0);
      else begin
        e = sb.pop_front();
        chk("sb rdata", mem_rdata, e.data);
        chk("sb rlast", mem_rlast, e.last);
        chk("sb err", mem_err, e.err);
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst awvalid", axi.awvalid, 0);
    chk("rst wvalid", axi.wvalid, 0);
    chk("rst bready", axi.bready, 0);
    chk("rst arvalid", axi.arvalid, 0);
    chk("rst rready", axi.rready, 0);
    chk("rst wbeat_ok", mem_wbeat_ok, 0);
    chk("rst data_ok", mem_data_ok, 0);
    chk("rst rdata", mem_rdata, 0);
    chk("rst rlast", mem_rlast, 0);
    chk("rst err", mem_err, 0);
    chk("rst writing", writing, 0);
    chk("rst last_write_address", last_write_address, 0);
  endtask

  // All tasks enter and leave at a falling clock edge.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [2:0] mid,
                       input int len);
    int n = 0;
    mem_req = 1'b1; mem_wen = wen; mem_address = addr; mem_match_id = mid;
    mem_len = 4'(len); mem_size = 3'd2;
    #1;
    while (!mem_addr_ok && n < 20) begin @(negedge clk); #1; n++; end
    chk("addr_ok", mem_addr_ok, 1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic aw_hs(input logic [31:0] ea, input logic [6:0] eid, input int len);
    int n = 0;
    #1;
    while (!axi.awvalid && n < 20) begin @(negedge clk); #1; n++; end
    chk("aw latency", n, 0);
    chk("awvalid", axi.awvalid, 1);
    chk("awaddr", axi.awaddr, ea);
    chk("awid", axi.awid, eid);
    chk("awlen", axi.awlen, len);
    chk("awburst", axi.awburst, 2'b01);
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] ea, input logic [6:0] eid, input int len);
    int n = 0;
    #1;
    while (!axi.arvalid && n < 20) begin @(negedge clk); #1; n++; end
    chk("ar latency", n, 0);
    chk("arvalid", axi.arvalid, 1);
    chk("araddr", axi.araddr, ea);
    chk("arid", axi.arid, eid);
    chk("arlen", axi.arlen, len);
    chk("arburst", axi.arburst, 2'b01);
    axi.arready = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
  endtask

  task automatic write_data(input int len, input logic [31:0] seed);
    int k = 0;
    int cyc = 0;
    while (k <= len && cyc < 200) begin
      axi.wready = (cyc % 2 == 1);
      mem_wdata  = seed + 32'(k);
      mem_wmask  = 4'hF ^ 4'(k);
      #1;
      chk("wvalid", axi.wvalid, 1);
      chk("wdata", axi.wdata, seed + 32'(k));
      chk("wstrb", axi.wstrb, 4'hF ^ 4'(k));
      chk("wlast", axi.wlast, k == len);
      chk("wbeat_ok", mem_wbeat_ok, axi.wready);
      if (axi.wready) k++;
      @(negedge clk);
      cyc++;
    end
    axi.wready = 1'b0;
    chk("w beats", k, len + 1);
  endtask

  task automatic b_resp(input logic [1:0] resp);
    axi.bvalid = 1'b1; axi.bresp = resp;
    sb.push_back('{data: 32'h0, last: 1'b0, err: resp != 2'b00});
    #1;
    chk("wvalid after last", axi.wvalid, 0);
    chk("bready", axi.bready, 1);
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    chk("writing cleared", writing, 0);
    @(negedge clk);
  endtask

  task automatic deliver_beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
    axi.rvalid = 1'b1; axi.rdata = d; axi.rlast = last; axi.rresp = resp;
    mem_data_resp = 1'b1;
    sb.push_back('{data: d, last: last, err: resp != 2'b00});
    #1;
    chk("rready", axi.rready, 1);
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
  endtask

  task automatic do_read(input vec_t v, input int idx);
    logic [31:0] seed;
    seed = 32'hD000_0000 + 32'(idx * 256);
    issue(1'b0, v.addr, v.mid, v.len);
    ar_hs(v.exp_addr, v.exp_id, v.len);
    for (int k = 0; k <= v.len; k++) begin
      if (k == v.stall) begin
        axi.rvalid = 1'b1; axi.rdata = seed + 32'(k); axi.rlast = (k == v.len);
        axi.rresp = v.resp; mem_data_resp = 1'b0;
        #1;
        chk("rready stalled", axi.rready, 0);
        chk("no data_ok stalled", mem_data_ok, 0);
        @(negedge clk);
      end
      deliver_beat(seed + 32'(k), k == v.len, v.resp);
    end
    #1;
    chk("rready after rlast", axi.rready, 0);
    @(negedge clk);
  endtask

  task automatic do_write(input vec_t v, input int idx);
    issue(1'b1, v.addr, v.mid, v.len);
    aw_hs(v.exp_addr, v.exp_id, v.len);
    chk("writing", writing, 1);
    chk("last_write_address", last_write_address, v.addr);
    write_data(v.len, 32'hA500_0000 + 32'(idx * 256));
    b_resp(v.resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h1000_0040, 3'd3, 0,  2'b00, -1, 32'h0000_0040, 7'h31};
    vecs[1] = '{1'b0, 32'h2000_0100, 3'd1, 7,  2'b00, 3,  32'h0000_0100, 7'h13};
    vecs[2] = '{1'b1, 32'h3000_0000, 3'd2, 3,  2'b00, -1, 32'h0000_0000, 7'h27};
    vecs[3] = '{1'b1, 32'h4000_0010, 3'd5, 1,  2'b10, -1, 32'h0000_0010, 7'h5F};
    vecs[4] = '{1'b0, 32'h9000_0008, 3'd7, 2,  2'b10, -1, 32'h0000_0008, 7'h71};
    vecs[5] = '{1'b0, 32'h0000_0004, 3'd0, 0,  2'b00, -1, 32'h0000_0004, 7'h01};
    vecs[6] = '{1'b1, 32'hF000_0020, 3'd4, 15, 2'b00, -1, 32'h0000_0020, 7'h41};

    rst_n = 1'b0;
    mem_req = 0; mem_wen = 0; mem_address = 0; mem_size = 0; mem_len = 0; mem_match_id = 0;
    mem_wdata = 0; mem_wmask = 0; mem_data_resp = 0;
    axi.awready = 0; axi.wready = 0; axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
    axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
    repeat (2) @(negedge clk);
    check_reset_outs();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wen) do_write(vecs[i], i);
      else             do_read(vecs[i], i);
    end

    // B response and R beat collide: R first, B completion one cycle later.
    issue(1'b1, 32'h1000_0080, 3'd1, 0);
    aw_hs(32'h80, 7'h11, 0);
    write_data(0, 32'hB000_0000);
    issue(1'b0, 32'h1000_0200, 3'd2, 0);
    ar_hs(32'h200, 7'h21, 0);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_0001; axi.rlast = 1'b1; axi.rresp = 2'b00;
    mem_data_resp = 1'b1;
    sb.push_back('{data: 32'hCAFE_0001, last: 1'b1, err: 1'b0});
    #1;
    chk("bready held on collision", axi.bready, 0);
    chk("rready on collision", axi.rready, 1);
    @(negedge clk);
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    sb.push_back('{data: 32'h0, last: 1'b0, err: 1'b0});
    #1;
    chk("bready after collision", axi.bready, 1);
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    chk("writing after collision", writing, 0);
    @(negedge clk);

    // Read to the address of an outstanding write.
    issue(1'b1, 32'h2000_0300, 3'd6, 0);
    aw_hs(32'h300, 7'h63, 0);
    write_data(0, 32'hC000_0000);
    mem_req = 1'b1; mem_wen = 1'b0; mem_address = 32'h2000_0300; mem_match_id = 3'd6;
    mem_len = 4'd0;
`ifdef SRAMBUS2AXI_RAW_CHECK_EN
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("raw stall", mem_addr_ok, 0);
      @(negedge clk);
    end
    b_resp(2'b00);
    #1;
    chk("raw release", mem_addr_ok, 1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    ar_hs(32'h300, 7'h63, 0);
    deliver_beat(32'h5A5A_0300, 1'b1, 2'b00);
`else
    #1;
    chk("no raw check", mem_addr_ok, 1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    ar_hs(32'h300, 7'h63, 0);
    deliver_beat(32'h5A5A_0300, 1'b1, 2'b00);
    b_resp(2'b00);
`endif

    // Reset while beat 2 of a 4-beat read is on the bus.
    issue(1'b0, 32'h1000_0400, 3'd0, 3);
    ar_hs(32'h400, 7'h01, 3);
    deliver_beat(32'hE000_0000, 1'b0, 2'b00);
    deliver_beat(32'hE000_0001, 1'b0, 2'b00);
    axi.rvalid = 1'b1; axi.rdata = 32'hE000_0002; mem_data_resp = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    axi.rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(vecs[0], 0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
